// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit blocks: FSM state codes,
// parity mode constants and the bit-timer counter width helper.
package uart_pkg;

  // Receiver FSM state codes; kept as plain constants for legacy tooling.
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t StIdle   = 3'd0;
  localparam uart_state_t StStart  = 3'd1;
  localparam uart_state_t StData   = 3'd2;
  localparam uart_state_t StParity = 3'd3;
  localparam uart_state_t StStop   = 3'd4;

  // Parity modes carried by the PARITY parameter.
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Width of a counter that must reach clks_per_bit - 1.
  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    return (clks_per_bit > 1) ? int'($clog2(clks_per_bit)) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-running counter with synchronous clear and a tick at
// either the half-bit or the full-bit terminal count. Shared with the TX side.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic half_i,
  output logic tick_o
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] FullTc = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfTc = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Terminal-count detect and next count.
  always_comb begin
    tick_o = (cnt_q == (half_i ? HalfTc : FullTc));
    cnt_d  = clr_i ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive sampler/deserialiser. Detects a start bit on the synchronised
// line, rejects false starts, samples each bit at its centre (LSB first),
// checks optional parity and 1/2 stop bits, and emits a word with a one-cycle
// data_valid pulse plus sticky-until-next-frame error flags.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN (3-sample majority vote per bit).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [3:0]           bit_idx
);

  localparam int unsigned ParBits = (PARITY != PAR_NONE) ? 1 : 0;
  localparam logic        ParOdd  = (PARITY == PAR_ODD);
  // bit_idx values seen just before the last data sample and last stop sample.
  localparam logic [3:0] LastDataIdx = 4'(DATA_BITS - 1);
  localparam logic [3:0] LastStopIdx = 4'(DATA_BITS + ParBits + STOP_BITS - 1);

  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic rx_fall, samp, tick, timer_clr, timer_half;

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic                 dv_q, dv_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  // Two-flop synchroniser plus previous-value register for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Last two synchronised samples, so the vote sees target-2, target-1, target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign samp = rx_s_q;
`endif

  // Counter held clear in IDLE so every state entry and every sample restarts it.
  assign timer_clr  = (state_q == StIdle) || tick;
  assign timer_half = (state_q == StStart);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (timer_clr),
    .half_i (timer_half),
    .tick_o (tick)
  );

  // Frame FSM: next state, shift register and output staging.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    data_d      = data_q;
    dv_d        = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    case (state_q)
      StIdle: begin
        // A line held low (break) produces no edge and stays here.
        if (rx_fall) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (tick) begin
          if (samp) begin
            // False start: leave every visible output untouched.
            state_d = StIdle;
          end else begin
            state_d     = StData;
            bit_idx_d   = '0;
            perr_pend_d = 1'b0;
            ferr_pend_d = 1'b0;
          end
        end
      end

      StData: begin
        if (tick) begin
          shift_d   = {samp, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == LastDataIdx) begin
            state_d = (ParBits != 0) ? StParity : StStop;
          end
        end
      end

      StParity: begin
        if (tick) begin
          bit_idx_d   = bit_idx_q + 4'd1;
          perr_pend_d = ((^shift_q) ^ samp) != ParOdd;
          state_d     = StStop;
        end
      end

      StStop: begin
        if (tick) begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (!samp) begin
            ferr_pend_d = 1'b1;
          end
          if (bit_idx_q == LastStopIdx) begin
            // Straight back to IDLE so a start bit right after the stop is caught.
            state_d = StIdle;
            data_d  = shift_q;
            dv_d    = 1'b1;
            perr_d  = perr_pend_q;
            ferr_d  = ferr_pend_q | ~samp;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != StIdle);
  assign bit_idx    = bit_idx_q;

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Parametrised UART receive sampler and deserialiser: the next generation of the team's bit-centre strobe generator.
- Detects the start bit, rejects false starts, samples every bit at its centre and shifts data LSB first.
- Checks optional parity and 1 or 2 stop bits, then presents a word with a one-cycle valid pulse and error flags.
- Sits between the board RX pin and the command/control logic, in the main clock domain.

Parameters:
- CLKS_PER_BIT, 5208: clk cycles per bit (50 MHz / 9600 Bd); must be >= 8.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial line, idle high.
- data  out  DATA_BITS  received word; updated only on data_valid.
- data_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  parity mismatch on the last frame; 0 when PARITY = 0.
- frame_err  out  1  a stop bit was sampled low on the last frame.
- busy  out  1  high in every state except IDLE.
- bit_idx  out  4  index of the bit last sampled (0 = start), like the legacy strobe counter.

Behaviour:
- Reset, asynchronous and taking effect at any time, including mid-frame:
  - data = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0, bit_idx = 0.
  - State = IDLE, counter = 0, both synchroniser flops = 1.
- rx passes through a 2-FF synchroniser (rx_s); a previous-value register detects edges.
- Counter width is $clog2(CLKS_PER_BIT). It clears on every state entry and on every sample.
- IDLE:
  - rx_s falling edge (prev 1, now 0) -> START.
  - Line held low with no falling edge (break) stays in IDLE.
- START:
  - At count == CLKS_PER_BIT/2 - 1, sample the line.
  - Sample 1 -> IDLE (false start, no outputs change).
  - Sample 0 -> DATA, bit_idx = 0.
- DATA:
  - At count == CLKS_PER_BIT - 1, sample; shift in LSB first; bit_idx += 1.
  - After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
- PARITY:
  - One sample at the same spacing.
  - Error when XOR(data bits, parity bit) != (PARITY == 1 ? 1 : 0).
- STOP:
  - STOP_BITS samples; any sample of 0 sets the pending frame error.
  - On the final stop sample, in the next cycle: data <= shift register, data_valid = 1 for exactly one cycle.
  - parity_err and frame_err are loaded in that same cycle and hold until the next data_valid.
  - State -> IDLE, which allows back-to-back frames with no extra idle time.
- Frame error with the line still low: IDLE waits for a fresh falling edge, so a break yields exactly one frame with frame_err and no further frames.
- Latency: data_valid rises (1.5 + DATA_BITS + P + STOP_BITS - 1) * CLKS_PER_BIT + 1 cycles after the synchronised falling edge, where P = 1 if parity is enabled.
- A falling edge on rx during a frame has no effect; sampling is strictly counter-driven.

Optional Feature:
- Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the majority of three rx_s samples at count == target-2, target-1 and target. This applies to the start check, data, parity and stop bits, and suppresses single-cycle glitches.
- Not defined: one sample at count == target. The three-sample shift register and the vote logic are absent.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Parity mode constants: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - Helper function computing the counter width.
- One sub-module, uart_bit_timer:
  - Counter with a clear input, a half/full period select, and a tick output at the terminal count.
  - Reused later by the transmitter.

Test Plan (all with CLKS_PER_BIT = 16 for speed):
- Frame 0x55, 8N1 -> data = 0x55, a single data_valid pulse, parity_err = 0, frame_err = 0, busy low after the pulse.
- rx low for 5 cycles, then high -> no data_valid, busy returns to 0 by cycle 8 + sync latency.
- PARITY = 2, frame 0xA3 with parity bit 1 (wrong) -> data = 0xA3, parity_err = 1. A following 0xA3 frame with parity bit 0 -> parity_err = 0.
- Stop bit driven 0, then line held low for 100 bits -> exactly one data_valid with frame_err = 1. rx high then a 0x3C frame -> data = 0x3C, frame_err = 0.
- Frames 0x01, 0xFF, 0x80 back to back with no idle gap -> three data_valid pulses in order, no errors.
- reset asserted at bit 4 of a frame -> all outputs 0 immediately, asynchronously. After release, a full 0x7E frame is received correctly. With UART_RX_MAJORITY_VOTE_EN defined, a 1-cycle glitch inverted at bit centre still yields 0x7E.
